// File: rtl/genaxis_descriptor_scheduler.sv
// Round-robin scheduler that shares one descriptor-driven AXIS generator between NUM_CH descriptor sources.
// Optional feature: define GENAXIS_SCHED_DROP_ZERO_LEN_EN to accept-and-drop zero-length descriptors (adds drop_cnt_o).
module genaxis_descriptor_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int ID_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable_i,
  input  logic [NUM_CH-1:0]        ch_enable_i,
  input  logic [NUM_CH*48-1:0]     s_desc_data_i,
  input  logic [NUM_CH-1:0]        s_desc_valid_i,
  output logic [NUM_CH-1:0]        s_desc_ready_o,
  output logic [48+ID_WIDTH-1:0]   m_desc_data_o,
  output logic                     m_desc_valid_o,
  input  logic                     m_desc_ready_i,
  output logic                     busy_o,
  output logic [31:0]              issued_cnt_o
`ifdef GENAXIS_SCHED_DROP_ZERO_LEN_EN
  ,
  output logic [31:0]              drop_cnt_o
`endif
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_e;

  slot_e                   slotState_q;
  logic [PW-1:0]           lastGrant_q;
  logic [48+ID_WIDTH-1:0]  descData_q;
  logic [48+ID_WIDTH-1:0]  descData_d;
  logic [31:0]             issuedCnt_q;

  logic                    canLoad;
  logic [NUM_CH-1:0]       eligible;
  logic                    grantValid;
  logic [PW-1:0]           grantIdx;
  logic [PW-1:0]           candIdx;
  logic [47:0]             grantDesc;
  logic                    dropEn;
  logic                    loadEn;
  logic                    popEn;

  assign popEn    = (slotState_q == SLOT_FULL) && m_desc_ready_i;
  assign canLoad  = (slotState_q == SLOT_EMPTY) || m_desc_ready_i;
  assign eligible = s_desc_valid_i & ch_enable_i & {NUM_CH{enable_i}};

  // Search starts one past the last granted channel and wraps, so every source gets a fair turn.
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    candIdx    = '0;
    if (canLoad) begin
      for (int i = 1; i <= NUM_CH; i++) begin
        candIdx = PW'((int'(lastGrant_q) + i) % NUM_CH);
        if (!grantValid && eligible[candIdx]) begin
          grantValid = 1'b1;
          grantIdx   = candIdx;
        end
      end
    end
  end

  always_comb begin
    grantDesc      = '0;
    s_desc_ready_o = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grantIdx == PW'(k)) begin
        grantDesc         = s_desc_data_i[48*k +: 48];
        s_desc_ready_o[k] = grantValid;
      end
    end
  end

`ifdef GENAXIS_SCHED_DROP_ZERO_LEN_EN
  logic [31:0] dropCnt_q;

  assign dropEn     = grantValid && (grantDesc[15:0] == 16'd0);
  assign drop_cnt_o = dropCnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dropCnt_q <= '0;
    end else if (dropEn) begin
      dropCnt_q <= dropCnt_q + 32'd1;
    end
  end
`else
  assign dropEn = 1'b0;
`endif

  assign loadEn     = grantValid && !dropEn;
  assign descData_d = {ID_WIDTH'(grantIdx), grantDesc};

  // Single output slot: a load wins over a drain so back-to-back grants keep the slot FULL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slotState_q <= SLOT_EMPTY;
      lastGrant_q <= PW'(NUM_CH - 1);
      descData_q  <= '0;
      issuedCnt_q <= '0;
    end else begin
      if (grantValid) begin
        lastGrant_q <= grantIdx;
      end
      if (loadEn) begin
        slotState_q <= SLOT_FULL;
        descData_q  <= descData_d;
      end else if (popEn) begin
        slotState_q <= SLOT_EMPTY;
      end
      if (popEn) begin
        issuedCnt_q <= issuedCnt_q + 32'd1;
      end
    end
  end

  assign m_desc_valid_o = (slotState_q == SLOT_FULL);
  assign busy_o         = (slotState_q == SLOT_FULL);
  assign m_desc_data_o  = descData_q;
  assign issued_cnt_o   = issuedCnt_q;

endmodule

// File: tb/tb_genaxis_descriptor_scheduler.sv
// Scoreboard bench for genaxis_descriptor_scheduler: directed vectors push expected descriptors, a monitor pops on handshakes.
// Build with GENAXIS_SCHED_DROP_ZERO_LEN_EN defined to exercise the zero-length drop path.
module tb_genaxis_descriptor_scheduler;

  localparam int NUM_CH   = 4;
  localparam int ID_WIDTH = 10;
  localparam int DW       = 48 + ID_WIDTH;

  logic                 clk;
  logic                 reset_n;
  logic                 enableIn;
  logic [NUM_CH-1:0]    chEnable;
  logic [NUM_CH*48-1:0] sDescData;
  logic [NUM_CH-1:0]    sDescValid;
  logic [NUM_CH-1:0]    sDescReady;
  logic [DW-1:0]        mDescData;
  logic                 mDescValid;
  logic                 mDescReady;
  logic                 busy;
  logic [31:0]          issuedCnt;
`ifdef GENAXIS_SCHED_DROP_ZERO_LEN_EN
  logic [31:0]          dropCnt;
`endif

  int checkCount = 0;
  int errorCount = 0;
  logic [DW-1:0] expQ[$];

  genaxis_descriptor_scheduler #(
    .NUM_CH   (NUM_CH),
    .ID_WIDTH (ID_WIDTH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable_i       (enableIn),
    .ch_enable_i    (chEnable),
    .s_desc_data_i  (sDescData),
    .s_desc_valid_i (sDescValid),
    .s_desc_ready_o (sDescReady),
    .m_desc_data_o  (mDescData),
    .m_desc_valid_o (mDescValid),
    .m_desc_ready_i (mDescReady),
    .busy_o         (busy),
    .issued_cnt_o   (issuedCnt)
`ifdef GENAXIS_SCHED_DROP_ZERO_LEN_EN
    ,
    .drop_cnt_o     (dropCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] valid, input logic [NUM_CH-1:0] chEn,
                               input logic en, input logic rdy);
    sDescValid = valid;
    chEnable   = chEn;
    enableIn   = en;
    mDescReady = rdy;
  endtask

  task automatic setDesc(input int ch, input logic [31:0] pause, input logic [15:0] len);
    sDescData[48*ch +: 48] = {pause, len};
  endtask

  function automatic logic [DW-1:0] expDesc(input int ch, input logic [31:0] pause, input logic [15:0] len);
    return {ID_WIDTH'(ch), pause, len};
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every handshake and checks AXIS hold rules between handshakes.
  logic          prevHold = 1'b0;
  logic [DW-1:0] prevData = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        checkOutput("hold_valid", 64'(mDescValid), 64'd1);
        checkOutput("hold_data", 64'(mDescData), 64'(prevData));
      end
      if (mDescValid && mDescReady) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", 64'(mDescData), 64'hDEAD);
        end else begin
          checkOutput("desc_data", 64'(mDescData), 64'(expQ.pop_front()));
        end
      end
      prevHold = mDescValid && !mDescReady;
      prevData = mDescData;
    end
  end

  initial begin
    reset_n    = 1'b0;
    sDescData  = '0;
    applyStimulus('0, '0, 1'b0, 1'b0);
    for (int k = 0; k < NUM_CH; k++) setDesc(k, 32'(100 + k), 16'(16 + k));

    #2;
    checkOutput("rst_valid", 64'(mDescValid), 64'd0);
    checkOutput("rst_data", 64'(mDescData), 64'd0);
    checkOutput("rst_issued", 64'(issuedCnt), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
`ifdef GENAXIS_SCHED_DROP_ZERO_LEN_EN
    checkOutput("rst_drop", 64'(dropCnt), 64'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    nextCycle();

    // Round robin across all channels at full throughput
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("rr_ready", 64'(sDescReady), 64'(4'b0001 << (i % 4)));
      expQ.push_back(expDesc(i % 4, 32'(100 + i % 4), 16'(16 + i % 4)));
      nextCycle();
    end
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1);
    nextCycle();
    checkOutput("rr_issued", 64'(issuedCnt), 64'd8);
    checkOutput("rr_idle_valid", 64'(mDescValid), 64'd0);

    // Channel 2 alone, downstream stalled for three cycles
    setDesc(2, 32'd5, 16'd64);
    applyStimulus(4'b0100, 4'b1111, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("ch2_grant", 64'(sDescReady), 64'(4'b0100));
    expQ.push_back(expDesc(2, 32'd5, 16'd64));
    nextCycle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("ch2_ready_full", 64'(sDescReady), 64'd0);
      checkOutput("ch2_held_valid", 64'(mDescValid), 64'd1);
      checkOutput("ch2_held_data", 64'(mDescData), {6'd0, 10'd2, 32'd5, 16'd64});
      nextCycle();
    end
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1);
    nextCycle();
    checkOutput("ch2_drained", 64'(mDescValid), 64'd0);
    checkOutput("ch2_issued", 64'(issuedCnt), 64'd9);
    setDesc(2, 32'd102, 16'd18);

    // Channel mask 1010: pointer is at 2, so order is 3,1,3,1
    applyStimulus(4'b1111, 4'b1010, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("mask_ready", 64'(sDescReady), (i % 2 == 0) ? 64'(4'b1000) : 64'(4'b0010));
      if (i % 2 == 0) expQ.push_back(expDesc(3, 32'd103, 16'd19));
      else            expQ.push_back(expDesc(1, 32'd101, 16'd17));
      nextCycle();
    end
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1);
    nextCycle();
    checkOutput("mask_issued", 64'(issuedCnt), 64'd13);

    // Global enable drops while the slot is FULL
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("en_grant", 64'(sDescReady), 64'(4'b0100));
    expQ.push_back(expDesc(2, 32'd102, 16'd18));
    nextCycle();
    applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("en_off_ready", 64'(sDescReady), 64'd0);
    checkOutput("en_off_valid", 64'(mDescValid), 64'd1);
    nextCycle();
    applyStimulus(4'b1111, 4'b1111, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("en_off_ready_drain", 64'(sDescReady), 64'd0);
    nextCycle();
    checkOutput("en_off_empty", 64'(mDescValid), 64'd0);
    checkOutput("en_off_busy", 64'(busy), 64'd0);
    checkOutput("en_off_ready_after", 64'(sDescReady), 64'd0);
    checkOutput("en_off_issued", 64'(issuedCnt), 64'd14);

    // Asynchronous reset in the middle of a stalled transfer
    applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
    nextCycle();
    checkOutput("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(mDescValid), 64'd0);
    checkOutput("arst_data", 64'(mDescData), 64'd0);
    checkOutput("arst_issued", 64'(issuedCnt), 64'd0);
    checkOutput("arst_busy", 64'(busy), 64'd0);
    mDescReady = 1'b1;
    @(negedge clk);
    #3;
    reset_n = 1'b1;
    #1;
    checkOutput("post_rst_grant", 64'(sDescReady), 64'(4'b0001));
    expQ.push_back(expDesc(0, 32'd100, 16'd16));
    nextCycle();
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1);
    nextCycle();
    checkOutput("post_rst_issued", 64'(issuedCnt), 64'd1);

    // Zero-length descriptor on channel 1
    setDesc(1, 32'd7, 16'd0);
    applyStimulus(4'b0010, 4'b1111, 1'b1, 1'b1);
    #1;
    checkOutput("zero_len_ready", 64'(sDescReady), 64'(4'b0010));
`ifndef GENAXIS_SCHED_DROP_ZERO_LEN_EN
    expQ.push_back(expDesc(1, 32'd7, 16'd0));
`endif
    nextCycle();
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1);
    nextCycle();
`ifdef GENAXIS_SCHED_DROP_ZERO_LEN_EN
    checkOutput("zero_len_drop_cnt", 64'(dropCnt), 64'd1);
    checkOutput("zero_len_issued", 64'(issuedCnt), 64'd1);
    checkOutput("zero_len_valid", 64'(mDescValid), 64'd0);
`else
    checkOutput("zero_len_issued", 64'(issuedCnt), 64'd2);
`endif

    repeat (2) nextCycle();
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
